// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and decode helpers for the LSU data-memory slave
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } funct_e;

  typedef enum logic [1:0] {
    IDLE,
    WORD0,
    WORD1,
    DONE
  } state_e;

  function automatic logic [2:0] size_of(input logic [2:0] funct);
    case (funct)
      LB, LBU: return 3'd1;
      LH, LHU: return 3'd2;
      LW:      return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic legal_funct(input logic [2:0] funct, input logic write);
    case (funct)
      LB, LH, LW: return 1'b1;
      LBU, LHU:   return !write;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_apb_ctrl_if.sv
// rtl/lsu_dmem_apb_ctrl_if.sv - APB-style bus between the LSU master and the data-memory slave
interface lsu_dmem_apb_ctrl_if #(parameter int DMEM_W = 11) ();
  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [DMEM_W-1:0] paddr_i;
  logic [31:0]       pwdata_i;
  logic [2:0]        pfunct_code_i;
  logic [31:0]       prdata_o;
  logic              pready_o;
  logic              pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pfunct_code_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pfunct_code_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/lsu_dmem_sram.sv
// rtl/lsu_dmem_sram.sv - single-port byte-lane SRAM, synchronous write, registered read
module lsu_dmem_sram #(
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/lsu_dmem_apb_ctrl.sv
// rtl/lsu_dmem_apb_ctrl.sv - APB data-memory slave with registered read and split misaligned accesses
module lsu_dmem_apb_ctrl
  import lsu_pkg::*;
#(
  parameter int DMEM_W      = 11,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  lsu_dmem_apb_ctrl_if.slave  bus
);
  localparam int AW = DMEM_W - 2;

  state_e            state_q, state_d;
  logic [DMEM_W-1:0] addr_q;
  logic [2:0]        funct_q;
  logic              write_q, cross_q;
  logic [31:0]       wdata_q, asm_q, asm_d;
  logic [31:0]       prdata_q;
  logic              pready_q, pslverr_q;

  logic              setup, cross_in, err_in;
  logic [2:0]        size_in, size_q;
  logic [1:0]        off_q;
  logic [7:0]        lane_mask;
  logic [5:0]        sh_a, sh_b;
  logic [AW-1:0]     word_a, word_b, mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata, mem_rdata;

  function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] v);
    case (f)
      LB:      return {{24{v[7]}}, v[7:0]};
      LH:      return {{16{v[15]}}, v[15:0]};
      LBU:     return {24'b0, v[7:0]};
      LHU:     return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign setup    = bus.psel_i && !bus.penable_i;
  assign size_in  = size_of(bus.pfunct_code_i);
  assign cross_in = ({2'b00, bus.paddr_i[1:0]} + {1'b0, size_in}) > 4'd4;
  assign err_in   = !legal_funct(bus.pfunct_code_i, bus.pwrite_i) || (cross_in && !MISALIGN_EN);

  assign off_q     = addr_q[1:0];
  assign size_q    = size_of(funct_q);
  // Bits [3:0] are the lanes of word A, bits [7:4] spill into word A+1.
  assign lane_mask = ((8'd1 << size_q) - 8'd1) << off_q;
  assign sh_a      = {1'b0, off_q, 3'b000};
  assign sh_b      = 6'd32 - sh_a;
  assign word_a    = addr_q[DMEM_W-1:2];
  assign word_b    = word_a + AW'(1);

  // Reads are issued one cycle early (setup for word A, WORD0 for word A+1)
  // so the registered SRAM data lands in the beat that consumes it.
  always_comb begin
    mem_addr  = word_b;
    mem_we    = 4'b0000;
    mem_wdata = wdata_q << sh_a;
    case (state_q)
      IDLE:  mem_addr = bus.paddr_i[DMEM_W-1:2];
      WORD0: if (write_q) begin
        mem_addr = word_a;
        if (bus.psel_i) mem_we = lane_mask[3:0];
      end
      WORD1: if (write_q && bus.psel_i) begin
        mem_we    = lane_mask[7:4];
        mem_wdata = wdata_q >> sh_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    asm_d = mem_rdata >> sh_a;
    if (state_q == WORD1) asm_d = asm_q | (mem_rdata << sh_b);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = err_in ? DONE : WORD0;
      WORD0:   state_d = !bus.psel_i ? IDLE : (cross_q ? WORD1 : DONE);
      WORD1:   state_d = bus.psel_i ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      funct_q   <= '0;
      write_q   <= 1'b0;
      cross_q   <= 1'b0;
      wdata_q   <= '0;
      asm_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      if (state_q == IDLE && setup) begin
        addr_q  <= bus.paddr_i;
        funct_q <= bus.pfunct_code_i;
        write_q <= bus.pwrite_i;
        cross_q <= cross_in;
        wdata_q <= bus.pwdata_i;
      end
      if (state_q == WORD0) asm_q <= asm_d;
      pready_q  <= (state_d == DONE);
      pslverr_q <= (state_q == IDLE) && (state_d == DONE);
      prdata_q  <= ((state_q == WORD0 || state_q == WORD1) && state_d == DONE && !write_q)
                   ? extend(funct_q, asm_d) : 32'h0;
    end
  end

  assign bus.prdata_o  = prdata_q;
  assign bus.pready_o  = pready_q;
  assign bus.pslverr_o = pslverr_q;

  lsu_dmem_sram #(.AW(AW)) u_sram (
    .clk_i (clk_i),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_lsu_dmem_apb_ctrl.sv
// tb/tb_lsu_dmem_apb_ctrl.sv - scoreboard bench for lsu_dmem_apb_ctrl, split and non-split builds
module tb_lsu_dmem_apb_ctrl;
  import lsu_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, tgt = 1'b0;
  logic [10:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [2:0]  funct = '0;
  logic        rdy, err;
  logic [31:0] rd;
  int          n_chk = 0, n_fail = 0, cyc = 0, setup_cyc = 0, txn = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_dmem_apb_ctrl_if #(.DMEM_W(11)) b_en ();
  lsu_dmem_apb_ctrl_if #(.DMEM_W(11)) b_na ();

  assign b_en.psel_i = psel && !tgt;
  assign b_na.psel_i = psel && tgt;
  assign b_en.penable_i = penable;      assign b_na.penable_i = penable;
  assign b_en.pwrite_i = pwrite;        assign b_na.pwrite_i = pwrite;
  assign b_en.paddr_i = paddr;          assign b_na.paddr_i = paddr;
  assign b_en.pwdata_i = pwdata;        assign b_na.pwdata_i = pwdata;
  assign b_en.pfunct_code_i = funct;    assign b_na.pfunct_code_i = funct;

  assign rdy = tgt ? b_na.pready_o  : b_en.pready_o;
  assign err = tgt ? b_na.pslverr_o : b_en.pslverr_o;
  assign rd  = tgt ? b_na.prdata_o  : b_en.prdata_o;

  lsu_dmem_apb_ctrl #(.DMEM_W(11), .MISALIGN_EN(1'b1)) dut_en (.clk_i(clk), .rst_i(rst), .bus(b_en));
  lsu_dmem_apb_ctrl #(.DMEM_W(11), .MISALIGN_EN(1'b0)) dut_na (.clk_i(clk), .rst_i(rst), .bus(b_na));

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: every pready pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pready: got pready=1, expected no transfer pending");
      end else begin
        e = exp_q.pop_front();
        check32($sformatf("txn%0d_prdata", e.id), rd, e.rdata);
        check32($sformatf("txn%0d_pslverr", e.id), {31'b0, err}, {31'b0, e.err});
        check32($sformatf("txn%0d_latency", e.id), 32'(cyc - setup_cyc), 32'(e.lat));
      end
    end
  end

  // Called at posedge+1; leaves the bus idle at posedge+1 so calls run back-to-back.
  task automatic xfer(input logic t, input logic wr, input logic [2:0] f, input logic [10:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    int   n;
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; funct = f; paddr = a; pwdata = wd;
    setup_cyc = cyc;
    txn++;
    e.id = txn; e.rdata = er; e.err = ee; e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk); #1 penable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy && n < 8);
    if (!rdy) begin
      n_chk++; n_fail++;
      $display("FAIL txn%0d_timeout: got no pready in %0d cycles, expected pready", txn, n);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100000 ns, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check32("reset_pready", {31'b0, b_en.pready_o}, 32'h0);
    check32("reset_pslverr", {31'b0, b_en.pslverr_o}, 32'h0);
    check32("reset_prdata", b_en.prdata_o, 32'h0);
    rst = 1'b0;

    // aligned word and byte lanes
    xfer(0, 1, LW,  11'h010, 32'hDEADBEEF, 32'h0,        0, 2);
    xfer(0, 0, LW,  11'h010, 32'h0,        32'hDEADBEEF, 0, 2);
    xfer(0, 1, LB,  11'h013, 32'h00000080, 32'h0,        0, 2);
    xfer(0, 0, LB,  11'h013, 32'h0,        32'hFFFFFF80, 0, 2);
    xfer(0, 0, LBU, 11'h013, 32'h0,        32'h00000080, 0, 2);
    xfer(0, 0, LW,  11'h010, 32'h0,        32'h80ADBEEF, 0, 2);
    // crossing word store/load
    xfer(0, 1, LW,  11'h00C, 32'h0,        32'h0,        0, 2);
    xfer(0, 1, LW,  11'h00E, 32'h11223344, 32'h0,        0, 3);
    xfer(0, 0, LW,  11'h00E, 32'h0,        32'h11223344, 0, 3);
    xfer(0, 0, LW,  11'h00C, 32'h0,        32'h33440000, 0, 2);
    xfer(0, 0, LW,  11'h010, 32'h0,        32'h80AD1122, 0, 2);
    xfer(0, 0, LH,  11'h011, 32'h0,        32'hFFFFAD11, 0, 2);
    // top-word wrap
    xfer(0, 1, LW,  11'h7FC, 32'h0,        32'h0,        0, 2);
    xfer(0, 1, LW,  11'h000, 32'h0,        32'h0,        0, 2);
    xfer(0, 1, LH,  11'h7FF, 32'h0000A55A, 32'h0,        0, 3);
    xfer(0, 0, LHU, 11'h7FF, 32'h0,        32'h0000A55A, 0, 3);
    xfer(0, 0, LW,  11'h7FC, 32'h0,        32'h5A000000, 0, 2);
    xfer(0, 0, LW,  11'h000, 32'h0,        32'h000000A5, 0, 2);
    // illegal funct codes
    xfer(0, 1, 3'd3, 11'h000, 32'hFFFFFFFF, 32'h0,       1, 1);
    xfer(0, 1, LBU, 11'h000, 32'hFFFFFFFF, 32'h0,        1, 1);
    xfer(0, 0, 3'd3, 11'h000, 32'h0,       32'h0,        1, 1);
    xfer(0, 0, LW,  11'h000, 32'h0,        32'h000000A5, 0, 2);
    // split disabled
    xfer(1, 1, LW,  11'h000, 32'h01020304, 32'h0,        0, 2);
    xfer(1, 1, LW,  11'h001, 32'hFFFFFFFF, 32'h0,        1, 1);
    xfer(1, 0, LW,  11'h001, 32'h0,        32'h0,        1, 1);
    xfer(1, 0, 3'd3, 11'h000, 32'h0,       32'h0,        1, 1);
    xfer(1, 0, LW,  11'h000, 32'h0,        32'h01020304, 0, 2);
    xfer(1, 0, LH,  11'h002, 32'h0,        32'h00000102, 0, 2);
    xfer(1, 0, LBU, 11'h003, 32'h0,        32'h00000001, 0, 2);

    // reset in WORD1 of a crossing store
    xfer(0, 1, LW,  11'h020, 32'h0,        32'h0,        0, 2);
    xfer(0, 1, LW,  11'h024, 32'h0,        32'h0,        0, 2);
    tgt = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; funct = LW;
    paddr = 11'h022; pwdata = 32'hCAFEF00D;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check32("midreset_pready", {31'b0, b_en.pready_o}, 32'h0);
    check32("midreset_pslverr", {31'b0, b_en.pslverr_o}, 32'h0);
    check32("midreset_prdata", b_en.prdata_o, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    xfer(0, 0, LW,  11'h020, 32'h0,        32'hF00D0000, 0, 2);
    xfer(0, 0, LW,  11'h024, 32'h0,        32'h00000000, 0, 2);

    repeat (3) @(posedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_dmem_apb_ctrl.md
Name: lsu_dmem_apb_ctrl

Overview:
- Next-generation data-memory slave for the LSU: parametrised depth, full APB handshake (psel/penable/pready/pslverr), registered SRAM-style read, and hardware splitting of misaligned half/word accesses across two words.
- Sits between the LSU APB master and the byte-lane data memory.
- Replaces the combinational-read, aligned-only data bank.

Parameters:
- DMEM_W, 11, byte-address width; depth = 2**(DMEM_W-2) 32-bit words.
- MISALIGN_EN, 1, 1 = split accesses that cross a word; 0 = flag them with pslverr_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB access phase.
- pwrite_i  in  1  1 = store, 0 = load.
- paddr_i  in  DMEM_W  byte address.
- pwdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- pfunct_code_i  in  3  0 = LB/SB, 1 = LH/SH, 2 = LW/SW, 4 = LBU, 5 = LHU; others illegal.
- prdata_o  out  32  load data, extended; 0 except in the DONE cycle of a load.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error, valid with pready_o.

Behaviour:
- Reset (async, rst_i=1): FSM to IDLE; prdata_o, pready_o, pslverr_o = 0. Memory array is not reset. Reset mid-transfer aborts it; completed beat writes remain.
- All outputs are registered; no tri-state.
- FSM states: IDLE, WORD0, WORD1, DONE.
- IDLE, on setup cycle (psel_i=1, penable_i=0): latch address, funct, write, wdata. Compute:
  - off = addr[1:0]
  - size = 1/2/4 from funct
  - cross = (off+size > 4)
  - err = illegal funct, or (cross and MISALIGN_EN=0), or (store with funct 4/5)
  - Next state: err -> DONE; else WORD0.
- WORD0: access word A = addr[DMEM_W-1:2], lanes off..min(3, off+size-1).
  - Store: byte-lane write enables; pwdata byte k goes to lane off+k.
  - Load: registered read into assembly bytes 0..(3-off).
  - Next state: cross -> WORD1; else DONE.
- WORD1: word (A+1) mod depth (top word wraps to word 0), lanes 0..(off+size-5).
  - Store data bytes (4-off)..(size-1) go to lanes 0...
  - Load fills assembly bytes (4-off)...
  - Next state: DONE.
- DONE: pready_o=1 for exactly one cycle.
  - Load: prdata_o = extended assembly — funct 0 sign-extends bit 7, 1 sign-extends bit 15, 4/5 zero-extend, 2 passes all 32 bits.
  - pslverr_o = err. On error: no memory write, prdata_o = 0.
  - Next state: IDLE.
- Latency from setup cycle: aligned / non-crossing = pready in 2nd access cycle; crossing = 3rd; error = 1st.
- Master drops psel_i before pready_o: return to IDLE next cycle, no response; already-written beats persist.
- Back-to-back transfers: a setup cycle directly after DONE is accepted.
- Sub-word non-crossing misaligned accesses (e.g. LH at off=1) are a single WORD0 beat.
- No pready_o while in IDLE.

Decomposition:
- Package lsu_pkg:
  - funct_e enum (LB=0, LH=1, LW=2, LBU=4, LHU=5)
  - state_e enum
  - size_of(funct) function
  - legal_funct(funct, write) function
- Sub-module lsu_dmem_sram:
  - 4-lane byte-write-enable array, 2**(DMEM_W-2) x 32
  - synchronous write, registered read, one port
  - no reset on contents

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> pready_o in 2nd access cycle, prdata_o = 0xDEADBEEF, pslverr_o = 0.
- SB 0x013 data 0x80, then LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080; other lanes of word 4 unchanged.
- MISALIGN_EN=1: SW 0x00E data 0x11223344 -> word3 lanes 2,3 = 44,33; word4 lanes 0,1 = 22,11. LW 0x00E -> 0x11223344, pready_o in 3rd access cycle.
- Top-word wrap, DMEM_W=11: SH 0x7FF data 0xA55A -> byte 0x7FF = 0x5A, byte 0x000 = 0xA5. LHU 0x7FF -> 0x0000A55A.
- MISALIGN_EN=0 LW 0x001, and funct 3 -> pready_o in 1st access cycle with pslverr_o=1, prdata_o=0, memory unchanged.
- Assert rst_i during WORD1 of a crossing store -> outputs 0 immediately, FSM IDLE; word A updated, word A+1 unchanged; next LW accepted normally.
